// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t    : fetch control state (BOOT, RUN, DRAIN)
//   RESET_PC_DEFAULT : default PC of the first fetch after reset
//   INSTR_NOP        : canonical RV32I NOP (addi x0, x0, 0)
//   FIFO_W           : width of one buffered entry, {pc, instr}
//   align_word()     : forces an address onto a word boundary
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam int          FIFO_W           = 64;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
//   clk, rst_n  : clock, asynchronous active-low reset (pointers/count only)
//   flush       : synchronous clear; wins over push and pop in the same cycle
//   push        : write push_data at the tail
//   push_data   : entry to write
//   pop         : drop the head entry
//   head_data   : current head entry (meaningful only when !empty)
//   count       : number of valid entries, 0..DEPTH
//   full, empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign do_pop    = pop && !empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests to
// instruction memory, buffers returned words and hands {instruction, instr_pc}
// to decode. Redirects flush the buffer and discard stale in-flight responses.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr : request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data   : in-order response channel
//   redirect_valid, redirect_pc     : taken branch / jump from execute
//   instr_valid/ready               : handshake toward decode
//   instruction, instr_pc           : head instruction word and its PC
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(BUF_DEPTH);

  fetch_state_t state, state_nxt;

  logic [31:0]       fetch_pc;
  logic [31:0]       rsp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  out_after_rsp;
  logic [CNT_W:0]    in_use;
  logic              credit_ok;
  logic              req_fire;
  logic              rsp_drop;
  logic              rsp_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_W-1:0] head_data;

  // Every requested word needs a guaranteed FIFO slot, so in-flight and
  // buffered words together may not exceed the buffer depth.
  assign in_use        = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok     = (in_use < DEPTH_L);
  assign out_after_rsp = outstanding - CNT_W'(imem_rsp_valid);
  assign rsp_drop      = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_push      = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  // A pop in a redirect cycle is swallowed by the flush inside the FIFO.
  assign fifo_pop      = instr_valid && instr_ready;
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign imem_addr     = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // DRAIN is held exactly while stale responses remain to be discarded.
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        imem_req_valid = credit_ok && !redirect_valid;
        if (redirect_valid && (out_after_rsp != '0)) state_nxt = DRAIN;
      end
      DRAIN: begin
        imem_req_valid = credit_ok && !redirect_valid;
        if (redirect_valid) begin
          state_nxt = (out_after_rsp != '0) ? DRAIN : RUN;
        end else if (rsp_drop && (drop_cnt == CNT_W'(1))) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
        // Whatever is still in flight after this cycle belongs to the old path.
        drop_cnt <= out_after_rsp;
        fetch_pc <= align_word(redirect_pc);
        rsp_pc   <= align_word(redirect_pc);
      end else begin
        if (rsp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_push) rsp_pc   <= rsp_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (fifo_pop),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head is masked while empty so the unreset storage never reaches decode.
  assign instr_valid = !fifo_empty;
  assign instruction = instr_valid ? head_data[31:0]  : 32'h0;
  assign instr_pc    = instr_valid ? head_data[63:32] : 32'h0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_push && fifo_full) |-> fifo_pop);

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus; sel picks which DUT the memory, handshake and monitor serve.
  logic        rst_n, rst2_n, sel;
  logic        mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;

  logic        d1_req_valid, d1_instr_valid;
  logic [31:0] d1_addr, d1_instruction, d1_instr_pc;
  logic        d2_req_valid, d2_instr_valid;
  logic [31:0] d2_addr, d2_instruction, d2_instr_pc;

  logic d1_req_ready, d1_rsp_valid, d1_redirect, d1_instr_ready;
  logic d2_req_ready, d2_rsp_valid, d2_redirect, d2_instr_ready;
  assign d1_req_ready   = mem_req_ready  & ~sel;
  assign d2_req_ready   = mem_req_ready  &  sel;
  assign d1_rsp_valid   = mem_rsp_valid  & ~sel;
  assign d2_rsp_valid   = mem_rsp_valid  &  sel;
  assign d1_redirect    = redirect_valid & ~sel;
  assign d2_redirect    = redirect_valid &  sel;
  assign d1_instr_ready = instr_ready    & ~sel;
  assign d2_instr_ready = instr_ready    &  sel;

  logic        m_req_valid, m_rst_n, mon_valid;
  logic [31:0] m_addr, mon_pc, mon_instr;
  assign m_req_valid = sel ? d2_req_valid   : d1_req_valid;
  assign m_addr      = sel ? d2_addr        : d1_addr;
  assign m_rst_n     = sel ? rst2_n         : rst_n;
  assign mon_valid   = sel ? d2_instr_valid : d1_instr_valid;
  assign mon_pc      = sel ? d2_instr_pc    : d1_instr_pc;
  assign mon_instr   = sel ? d2_instruction : d1_instruction;

  fetch_unit dut1 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(d1_req_valid), .imem_req_ready(d1_req_ready), .imem_addr(d1_addr),
    .imem_rsp_valid(d1_rsp_valid), .imem_rsp_data(mem_rsp_data),
    .redirect_valid(d1_redirect), .redirect_pc(redirect_pc),
    .instr_valid(d1_instr_valid), .instr_ready(d1_instr_ready),
    .instruction(d1_instruction), .instr_pc(d1_instr_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .imem_req_valid(d2_req_valid), .imem_req_ready(d2_req_ready), .imem_addr(d2_addr),
    .imem_rsp_valid(d2_rsp_valid), .imem_rsp_data(mem_rsp_data),
    .redirect_valid(d2_redirect), .redirect_pc(redirect_pc),
    .instr_valid(d2_instr_valid), .instr_ready(d2_instr_ready),
    .instruction(d2_instruction), .instr_pc(d2_instr_pc)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Memory contents: each word is a fixed function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: in-order responses, configurable latency 1..3 cycles.
  int          lat     = 1;
  int          acc_cnt = 0;
  bit          pv[3];
  logic [31:0] pa[3];
  initial begin
    bit          acc;
    logic [31:0] acc_a;
    for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pa[i] = '0; end
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      acc   = m_req_valid && mem_req_ready && m_rst_n;
      acc_a = m_addr;
      if (acc) acc_cnt++;
      @(posedge clk);
      #1;
      if (!m_rst_n) begin
        for (int i = 0; i < 3; i++) pv[i] = 1'b0;
      end else begin
        pv[2] = pv[1]; pa[2] = pa[1];
        pv[1] = pv[0]; pa[1] = pa[0];
        pv[0] = acc;   pa[0] = acc_a;
      end
      mem_rsp_valid = pv[lat-1];
      mem_rsp_data  = pv[lat-1] ? mem_word(pa[lat-1]) : 32'h0;
    end
  end

  // Monitor: compares every consumed head against the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (mon_valid && instr_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr actual_pc=%h required=none", mon_pc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", mon_pc, e);
          check("instruction", mon_instr, mem_word(e));
        end
      end
    end
  end

  task automatic drain(input int bound);
    instr_ready = 1'b1;
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
    instr_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual_left=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Stops fetching, lets in-flight words land, then redirects to a clean state.
  task automatic quiesce(input logic [31:0] target);
    instr_ready   = 1'b0;
    mem_req_ready = 1'b0;
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; rst2_n = 1'b0; sel = 1'b0;
    mem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (3) tick();
    #1;
    check("rst_req_valid", 32'(d1_req_valid), 32'd0);
    check("rst_imem_addr", d1_addr, 32'h0);
    check("rst_instr_valid", 32'(d1_instr_valid), 32'd0);
    check("rst_instruction", d1_instruction, 32'h0);
    check("rst_instr_pc", d1_instr_pc, 32'h0);

    // Cycle 0 is BOOT, first request in cycle 1, first head in cycle 3.
    tick(); rst_n = 1'b1; #1;
    check("boot_no_req", 32'(d1_req_valid), 32'd0);
    tick(); #1;
    check("c1_req_valid", 32'(d1_req_valid), 32'd1);
    check("c1_req_addr", d1_addr, 32'h0);
    tick(); #1;
    check("c2_instr_valid", 32'(d1_instr_valid), 32'd0);
    tick(); #1;
    check("c3_instr_valid", 32'(d1_instr_valid), 32'd1);
    check("c3_instr_pc", d1_instr_pc, 32'h0);

    // Backpressure: decode stalled for 10 cycles.
    repeat (10) tick();
    #1;
    check("bp_requests", 32'(acc_cnt), 32'd2);
    check("bp_fifo_count", 32'(dut1.fifo_count), 32'd2);
    check("bp_instr_valid", 32'(d1_instr_valid), 32'd1);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    drain(100);

    // Redirect to 0x100 with two requests in flight (3-cycle memory).
    quiesce(32'h40);
    lat = 3;
    mem_req_ready = 1'b1;
    tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    check("redir_outstanding", 32'(dut1.outstanding), 32'd2);
    check("redir_no_req", 32'(d1_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("redir_drop_cnt", 32'(dut1.drop_cnt), 32'd2);
    check("redir_state", 32'(dut1.state), 32'(DRAIN));
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    drain(100);
    check("drain_drop_cnt", 32'(dut1.drop_cnt), 32'd0);
    check("drain_state", 32'(dut1.state), 32'(RUN));

    // Unaligned redirect target.
    quiesce(32'h0);
    lat = 1;
    mem_req_ready  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #1;
    check("unal_no_req", 32'(d1_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("unal_req_valid", 32'(d1_req_valid), 32'd1);
    check("unal_imem_addr", d1_addr, 32'h200);
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    drain(100);

    // Redirect in the same cycle as a response and a pop.
    quiesce(32'h300);
    lat = 1;
    mem_req_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(); #1;
      seen = d1_instr_valid;
    end
    check("coinc_head_seen", 32'(seen), 32'd1);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    #1;
    check("coinc_instr_valid", 32'(d1_instr_valid), 32'd0);
    check("coinc_fifo_count", 32'(dut1.fifo_count), 32'd0);
    check("coinc_drop_cnt", 32'(dut1.drop_cnt), 32'd0);
    check("coinc_req_valid", 32'(d1_req_valid), 32'd1);
    check("coinc_req_addr", d1_addr, 32'h400);
    exp_q.push_back(32'h400); exp_q.push_back(32'h404); exp_q.push_back(32'h408);
    drain(100);
    quiesce(32'h0);

    // Second core: reset PC near the top of the address space.
    sel = 1'b1;
    lat = 1;
    mem_req_ready = 1'b1;
    tick();
    rst2_n = 1'b1;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0004);
    drain(100);
    repeat (3) tick();
    #1;
    check("wrap_instr_valid", 32'(d2_instr_valid), 32'd1);
    tick();
    rst2_n = 1'b0;
    #1;
    check("mid_rst_req_valid", 32'(d2_req_valid), 32'd0);
    check("mid_rst_imem_addr", d2_addr, 32'hFFFF_FFF8);
    check("mid_rst_instr_valid", 32'(d2_instr_valid), 32'd0);
    check("mid_rst_instruction", d2_instruction, 32'h0);
    check("mid_rst_instr_pc", d2_instr_pc, 32'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
